// File: rtl/debounce_sync_if.sv
// rtl/debounce_sync_if.sv - push-button debouncer signal bundle
//
// Purpose: groups the raw button level and the debounced outputs.
// Signals:
//   in   raw push-button level (asynchronous to clk, may bounce)
//   out  registered debounced level
//   busy registered, 1 while a candidate level change is being qualified
// Modports:
//   master  drives in, observes out/busy (button side / testbench)
//   slave   receives in, drives out/busy (debounce_sync)
interface debounce_sync_if;
   logic in;
   logic out;
   logic busy;

   modport master (output in, input out, input busy);
   modport slave  (input in, output out, output busy);
endinterface

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchronizer plus four-state debounce FSM
//
// Purpose: synchronizes a bouncing push-button level into clk and only lets
// the output follow a new level after it has been held for DB_CYCLES+1
// consecutive synchronized cycles.
// Parameters:
//   DB_CYCLES  qualification length in clk cycles (1 .. 2^CNT_W-1)
//   CNT_W      qualification counter width
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   db   debounce_sync_if.slave: in (raw), out (debounced), busy
module debounce_sync #(
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   debounce_sync_if.slave    db
);

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_WAIT_H = 2'd1,
      S_HIGH   = 2'd2,
      S_WAIT_L = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             ff1_q,   ff1_d;
   logic             sync_q,  sync_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             out_q,   out_d;
   logic             busy_q,  busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1_q   <= 1'b0;
         sync_q  <= 1'b0;
         state_q <= S_LOW;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ff1_q   <= ff1_d;
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      // Synchronizer: the only consumer of the raw input.
      ff1_d   = db.in;
      sync_d  = ff1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;

      case (state_q)
         S_LOW: begin
            cnt_d = '0;
            if (sync_q) state_d = S_WAIT_H;
         end
         S_WAIT_H: begin
            // Falling back to the current level is checked first so an
            // abort wins over terminal count in the same cycle.
            if (!sync_q) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HIGH;
               out_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HIGH: begin
            cnt_d = '0;
            if (!sync_q) state_d = S_WAIT_L;
         end
         S_WAIT_L: begin
            if (sync_q) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_LOW;
               out_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
            out_d   = 1'b0;
         end
      endcase

      // busy is registered alongside the state so it tracks the wait states.
      busy_d = (state_d == S_WAIT_H) || (state_d == S_WAIT_L);
   end

   assign db.out  = out_q;
   assign db.busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync (DB_CYCLES=4 and 1)
module tb_debounce_sync;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   debounce_sync_if if4();
   debounce_sync_if if1();

   debounce_sync #(.DB_CYCLES(4), .CNT_W(3)) dut4 (.clk(clk), .rst(rst), .db(if4.slave));
   debounce_sync #(.DB_CYCLES(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .db(if1.slave));

   int errors = 0;
   int checks = 0;

   // Reference model: out flips once the synchronized level has differed
   // from out for DB+1 consecutive edges; busy means such a run is open.
   bit [1:0] pipe [2];   // [1] = first flop, [0] = synchronized sample
   int       run  [2];
   bit       om   [2];
   int       dbv  [2] = '{4, 1};
   bit       inv  [2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         pipe[i] = 2'b00;
         run[i]  = 0;
         om[i]   = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      for (int i = 0; i < 2; i++) begin
         bit s;
         s       = pipe[i][0];
         pipe[i] = {inv[i], pipe[i][1]};
         if (s != om[i]) begin
            run[i]++;
            if (run[i] == dbv[i] + 1) begin
               om[i]  = ~om[i];
               run[i] = 0;
            end
         end else begin
            run[i] = 0;
         end
      end
      if (rst) model_reset();
   endfunction

   task automatic drive_in(input int i, input bit v);
      inv[i] = v;
      if (i == 0) if4.in = v;
      else        if1.in = v;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic test_reset();
      drive_in(0, 1'b0);
      drive_in(1, 1'b0);
      rst = 1'b1;
      model_reset();
      #3;
      checks++; if (if4.out !== 1'b0)  begin errors++; $display("FAIL reset_out4 got=%b exp=0", if4.out); end
      checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy4 got=%b exp=0", if4.busy); end
      checks++; if (if1.out !== 1'b0)  begin errors++; $display("FAIL reset_out1 got=%b exp=0", if1.out); end
      checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", if1.busy); end
      settle(2);
      rst = 1'b0;
      step();
      checks++; if (if4.out !== 1'b0 || if4.busy !== 1'b0)
         begin errors++; $display("FAIL post_reset_edge got=%b%b exp=00", if4.out, if4.busy); end
   endtask

   task automatic test_clean_press();
      drive_in(0, 1'b1);
      for (int e = 1; e <= 7; e++) begin
         step();
         checks++; if (if4.out !== (e >= 7))
            begin errors++; $display("FAIL press_out e=%0d got=%b exp=%b", e, if4.out, e >= 7); end
         checks++; if (if4.busy !== (e >= 3 && e < 7))
            begin errors++; $display("FAIL press_busy e=%0d got=%b exp=%b", e, if4.busy, e >= 3 && e < 7); end
      end
      settle(3);
   endtask

   task automatic test_clean_release();
      drive_in(0, 1'b0);
      for (int e = 1; e <= 7; e++) begin
         step();
         checks++; if (if4.out !== (e < 7))
            begin errors++; $display("FAIL release_out e=%0d got=%b exp=%b", e, if4.out, e < 7); end
      end
      settle(3);
   endtask

   task automatic test_release_bounce();
      drive_in(0, 1'b1);
      settle(10);
      checks++; if (if4.out !== 1'b1) begin errors++; $display("FAIL rb_pre got=%b exp=1", if4.out); end
      drive_in(0, 1'b0);
      settle(2);
      drive_in(0, 1'b1);
      for (int e = 1; e <= 12; e++) begin
         step();
         checks++; if (if4.out !== 1'b1)
            begin errors++; $display("FAIL rb_out e=%0d got=%b exp=1", e, if4.out); end
      end
   endtask

   task automatic test_bounce_press();
      bit saw_busy = 1'b0;
      drive_in(0, 1'b0);
      settle(10);
      drive_in(0, 1'b1);
      for (int e = 1; e <= 14; e++) begin
         step();
         if (e == 3) drive_in(0, 1'b0);
         if (if4.busy === 1'b1) saw_busy = 1'b1;
         checks++; if (if4.out !== 1'b0)
            begin errors++; $display("FAIL bp_out e=%0d got=%b exp=0", e, if4.out); end
      end
      checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL bp_busy_pulse got=%b exp=1", saw_busy); end
      checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got=%b exp=0", if4.busy); end
   endtask

   task automatic test_reset_mid();
      drive_in(0, 1'b1);
      settle(5);
      checks++; if (if4.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got=%b exp=1", if4.busy); end
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      checks++; if (if4.out !== 1'b0 || if4.busy !== 1'b0)
         begin errors++; $display("FAIL rm_async got=%b%b exp=00", if4.out, if4.busy); end
      settle(2);
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         checks++; if (if4.out !== (e >= 7))
            begin errors++; $display("FAIL rm_out e=%0d got=%b exp=%b", e, if4.out, e >= 7); end
      end
   endtask

   task automatic test_db1();
      drive_in(1, 1'b1);
      for (int e = 1; e <= 4; e++) begin
         step();
         checks++; if (if1.out !== (e >= 4))
            begin errors++; $display("FAIL db1_out e=%0d got=%b exp=%b", e, if1.out, e >= 4); end
      end
      drive_in(1, 1'b0);
      settle(8);
      checks++; if (if1.out !== 1'b0) begin errors++; $display("FAIL db1_release got=%b exp=0", if1.out); end
      drive_in(1, 1'b1);
      step();
      drive_in(1, 1'b0);
      for (int e = 1; e <= 8; e++) begin
         step();
         checks++; if (if1.out !== 1'b0)
            begin errors++; $display("FAIL db1_pulse e=%0d got=%b exp=0", e, if1.out); end
      end
   endtask

   task automatic test_random();
      int hold [2] = '{0, 0};
      int maxh [2] = '{8, 3};
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (hold[i] == 0) begin
               drive_in(i, ~inv[i]);
               hold[i] = $urandom_range(1, maxh[i]);
            end
            hold[i]--;
         end
         step();
         checks++; if (if4.out !== om[0] || if4.busy !== (run[0] != 0))
            begin errors++; $display("FAIL rand4 c=%0d got=%b%b exp=%b%b", c, if4.out, if4.busy, om[0], run[0] != 0); end
         checks++; if (if1.out !== om[1] || if1.busy !== (run[1] != 0))
            begin errors++; $display("FAIL rand1 c=%0d got=%b%b exp=%b%b", c, if1.out, if1.busy, om[1], run[1] != 0); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_clean_release();
      test_release_bounce();
      test_bounce_press();
      test_reset_mid();
      test_db1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
